// File: rtl/adc_spi_reader.sv
// adc_spi_reader: clocks 12-bit offset-binary samples out of an SPI ADC at a fixed rate
// and presents them as two's complement with a one-cycle valid strobe.
module adc_spi_reader #(
  parameter int CLK_DIV       = 4,
  parameter int LEAD_BITS     = 4,
  parameter int SAMPLE_PERIOD = 1042
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        adc_miso,
  output logic        adc_cs_n,
  output logic        adc_sclk,
  output logic        valid,
  output logic [11:0] sample_out,
  output logic        overrun
);
  localparam int FRAME = LEAD_BITS + 12;
  localparam int TW = $clog2(SAMPLE_PERIOD);
  localparam int DW = $clog2(CLK_DIV + 1);
  localparam int BW = $clog2(FRAME + 1);
  localparam logic [1:0] IDLE = 2'd0, SETUP = 2'd1, SHIFT = 2'd2, DONE = 2'd3;
  logic [1:0] state;
  logic [TW-1:0] timer;
  logic [DW-1:0] div;
  logic [BW-1:0] bits;
  logic [11:0] shreg;
  logic tick, phase_end;
  always_comb begin
    tick = timer == TW'(SAMPLE_PERIOD - 1);
    phase_end = div == DW'(CLK_DIV - 1);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      timer      <= '0;
      div        <= '0;
      bits       <= '0;
      shreg      <= '0;
      adc_cs_n   <= 1'b1;
      adc_sclk   <= 1'b1;
      valid      <= 1'b0;
      sample_out <= '0;
      overrun    <= 1'b0;
    end else begin
      timer <= tick ? '0 : timer + 1'b1;
      valid <= 1'b0;
      div   <= (state == IDLE || state == DONE || phase_end) ? '0 : div + 1'b1;
      if (tick && state != IDLE) overrun <= 1'b1;
      case (state)
        IDLE: if (tick) begin
          state    <= SETUP;
          adc_cs_n <= 1'b0;
          bits     <= '0;
        end
        SETUP: if (phase_end) begin
          state    <= SHIFT;
          adc_sclk <= 1'b0;
        end
        SHIFT: if (phase_end) begin
          // miso has had a full low phase to settle since the falling edge
          if (!adc_sclk) begin
            adc_sclk <= 1'b1;
            shreg    <= {shreg[10:0], adc_miso};
            bits     <= bits + 1'b1;
          end else if (bits == BW'(FRAME)) begin
            state      <= DONE;
            adc_cs_n   <= 1'b1;
            valid      <= 1'b1;
            sample_out <= {~shreg[11], shreg[10:0]};
          end else begin
            adc_sclk <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_adc_spi_reader.sv
// tb_adc_spi_reader: default build plus a short-period build, each driven by an ADC model
// and checked against per-frame expected timing, data and SCLK shape.
module tb_adc_spi_reader;
  localparam int CD = 4;
  localparam int K = CD * (1 + 2 * 16);
  localparam int SPA = 1042;
  localparam int SPB = 100;
  logic clk = 0;
  logic rst = 0;
  logic miso[2];
  logic cs_n[2], sclk[2], valid[2], ovr[2];
  logic [11:0] so[2];
  int cyc = 0;
  int tests = 0, fails = 0;
  int run[2], lowc[2], rises[2], idx[2], exp_cyc[2], last_v[2], nv[2];
  bit pend[2];
  logic [11:0] code[2], exp_val[2];
  logic [15:0] w;
  logic pcs[2], psc[2];
  logic [11:0] dir[4] = '{12'hFFF, 12'h800, 12'h000, 12'hA5C};
  int nf = 0;

  adc_spi_reader #(.CLK_DIV(CD), .LEAD_BITS(4), .SAMPLE_PERIOD(SPA)) dut_a (
    .clk(clk), .rst(rst), .adc_miso(miso[0]), .adc_cs_n(cs_n[0]), .adc_sclk(sclk[0]),
    .valid(valid[0]), .sample_out(so[0]), .overrun(ovr[0]));
  adc_spi_reader #(.CLK_DIV(CD), .LEAD_BITS(4), .SAMPLE_PERIOD(SPB)) dut_b (
    .clk(clk), .rst(rst), .adc_miso(miso[1]), .adc_cs_n(cs_n[1]), .adc_sclk(sclk[1]),
    .valid(valid[1]), .sample_out(so[1]), .overrun(ovr[1]));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  // a frame blocks every tick up to and including its DONE cycle (tick + K + 1)
  function automatic int spacing(input int sp);
    int n = 1;
    while (n * sp <= K + 1) n++;
    return n * sp;
  endfunction

  function automatic int sp_of(input int i);
    return i == 0 ? SPA : SPB;
  endfunction

  task automatic reset_checks();
    for (int i = 0; i < 2; i++) begin
      check("rst_cs_n", cs_n[i], 1);
      check("rst_sclk", sclk[i], 1);
      check("rst_valid", valid[i], 0);
      check("rst_sample", so[i], 0);
      check("rst_overrun", ovr[i], 0);
    end
  endtask

  task automatic first_fall();
    int n = 0;
    while (cs_n[0] && n < 2 * SPA) begin
      @(posedge clk);
      #1 n++;
    end
    check("first_cs_fall", n, SPA);
  endtask

  task automatic wait_valids(input int target);
    int t = 0;
    while (nv[0] < target && t < 20 * SPA) begin
      @(posedge clk);
      t++;
    end
    check("valid_count", nv[0] >= target, 1);
  endtask

  // ADC model plus frame monitor, evaluated mid-cycle
  initial begin
    for (int i = 0; i < 2; i++) begin
      nv[i] = 0;
      miso[i] = 0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (!rst) begin
          pend[i] = 0;
          last_v[i] = -1;
          pcs[i] = 1;
          psc[i] = 1;
          miso[i] = 0;
          rises[i] = 0;
        end else begin
          if (cs_n[i]) check("sclk_idle_high", sclk[i], 1);
          if (!cs_n[i] && pcs[i]) begin
            code[i] = (i == 0 && nf < 4) ? dir[nf] : 12'($urandom_range(0, 4095));
            if (i == 0) nf++;
            pend[i] = 1;
            exp_cyc[i] = cyc + K;
            exp_val[i] = code[i] ^ 12'h800;
            idx[i] = 0;
            run[i] = 1;
            lowc[i] = 1;
            rises[i] = 0;
          end else if (!cs_n[i]) begin
            lowc[i]++;
            if (sclk[i] != psc[i]) begin
              check("half_phase", run[i], CD);
              run[i] = 1;
              if (sclk[i]) rises[i]++;
              else begin
                w = {4'b0, code[i]};
                miso[i] = w[15 - idx[i]];
                idx[i]++;
              end
            end else run[i]++;
          end else if (!pcs[i]) begin
            check("half_phase", run[i], CD);
            check("cs_low_len", lowc[i], K);
            check("sclk_rises", rises[i], 16);
          end
          if (valid[i]) begin
            if (!pend[i]) check("unexpected_valid", 1, 0);
            else begin
              check("valid_cycle", cyc, exp_cyc[i]);
              check("sample", so[i], exp_val[i]);
              pend[i] = 0;
            end
            if (last_v[i] >= 0) check("valid_spacing", cyc - last_v[i], spacing(sp_of(i)));
            check("overrun", ovr[i], spacing(sp_of(i)) > sp_of(i));
            last_v[i] = cyc;
            nv[i]++;
          end else if (pend[i] && cyc > exp_cyc[i]) begin
            check("valid_late", 0, 1);
            pend[i] = 0;
          end
          pcs[i] = cs_n[i];
          psc[i] = sclk[i];
        end
      end
    end
  end

  initial begin
    int t;
    repeat (3) @(negedge clk);
    reset_checks();
    rst = 1;
    first_fall();
    wait_valids(12);
    t = 0;
    while (!(cs_n[0] == 0 && rises[0] >= 7) && t < 2 * SPA) begin
      @(negedge clk);
      t++;
    end
    check("reached_7th_rise", rises[0] >= 7, 1);
    @(posedge clk);
    #2 rst = 0;
    #1 reset_checks();
    repeat (3) @(negedge clk);
    rst = 1;
    first_fall();
    wait_valids(nv[0] + 2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
